// File: rtl/phy_rx_lane.sv
// Serial PHY receive lane: hunts for the COMMA symbol, locks byte alignment after
// LOCK_COUNT aligned COMMAs, then deserializes MSB-first bytes with a valid flag.
module phy_rx_lane #(
    parameter logic [7:0]  COMMA      = 8'hBC,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active,
    output logic       byte_strobe
);

    typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

    state_t     state, state_nx;
    logic [7:0] sr, sr_nx, data_nx;
    logic [2:0] bit_cnt, bit_cnt_nx;
    logic [3:0] comma_cnt, comma_cnt_nx;
    logic       valid_nx, active_nx, strobe_nx;
    logic       boundary, is_comma;

    assign sr_nx    = {sr[6:0], serial_in};
    assign is_comma = (sr_nx == COMMA);
    assign boundary = (bit_cnt == 3'd7);

    always_ff @(posedge clk_8f or posedge reset) begin
        if (reset) begin
            state       <= SEARCH;
            sr          <= '0;
            bit_cnt     <= '0;
            comma_cnt   <= '0;
            data_out    <= '0;
            valid_out   <= 1'b0;
            active      <= 1'b0;
            byte_strobe <= 1'b0;
        end else begin
            state       <= state_nx;
            sr          <= sr_nx;
            bit_cnt     <= bit_cnt_nx;
            comma_cnt   <= comma_cnt_nx;
            data_out    <= data_nx;
            valid_out   <= valid_nx;
            active      <= active_nx;
            byte_strobe <= strobe_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        bit_cnt_nx   = bit_cnt + 3'd1;
        comma_cnt_nx = comma_cnt;
        data_nx      = data_out;
        valid_nx     = valid_out;
        active_nx    = active;
        strobe_nx    = 1'b0;

        unique case (state)
            SEARCH: begin
                // Restart the bit counter so this detect edge behaves as a boundary
                if (is_comma) begin
                    bit_cnt_nx   = '0;
                    comma_cnt_nx = 4'd1;
                    state_nx     = ALIGN;
                end
            end
            ALIGN: begin
                if (boundary) begin
                    if (is_comma) begin
                        comma_cnt_nx = comma_cnt + 4'd1;
                        if (comma_cnt_nx == 4'(LOCK_COUNT)) begin
                            state_nx  = LOCKED;
                            active_nx = 1'b1;
                        end
                    end else begin
                        state_nx     = SEARCH;
                        comma_cnt_nx = '0;
                    end
                end
            end
            LOCKED: begin
                if (boundary) begin
                    strobe_nx = 1'b1;
                    if (is_comma) begin
                        valid_nx = 1'b0;
                    end else begin
                        data_nx  = sr_nx;
                        valid_nx = 1'b1;
                    end
                end
            end
            default: state_nx = SEARCH;
        endcase
    end

endmodule

// File: doc/phy_rx_lane.md
Name: phy_rx_lane

Overview:
- Receive end of one serial PHY lane: takes the 1-bit-per-clk_8f stream produced by a transmit lane and recovers byte alignment.
- The transmit lane sends COMMA (0xBC) when its byte stream is idle/invalid. This block hunts for COMMA and locks after LOCK_COUNT consecutive aligned COMMAs.
- Once locked, it deserializes bytes MSB-first and presents data bytes with a valid flag. COMMA bytes are treated as idle.
- Two instances, one per lane, feed the byte un-striping stage of the receive path.

Parameters:
- COMMA, 8'hBC, idle/alignment symbol; must not be 8'h00.
- LOCK_COUNT, 4, consecutive byte-aligned COMMAs required to declare lock; legal range 2..15.

Ports:
- clk_8f  input  1  bit clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- serial_in  input  1  serial lane bit, MSB of each byte first, sampled on rising clk_8f.
- data_out  output  8  last received data byte (held between updates).
- valid_out  output  1  1 = data_out holds a data byte; 0 = last byte was COMMA/idle.
- active  output  1  1 while in LOCKED.
- byte_strobe  output  1  one-cycle pulse on each byte boundary while LOCKED.

Behaviour:
- Reset (async, active-high), applies immediately regardless of clock:
  - state=SEARCH; shift register sr=0; bit_cnt=0; comma_cnt=0.
  - data_out=0, valid_out=0, active=0, byte_strobe=0.
- Shift register, every cycle: sr_next = {sr[6:0], serial_in}; sr <= sr_next. All comparisons below use sr_next, i.e. they include the bit sampled this edge.
- bit_cnt: 3-bit counter, wraps 7->0. A boundary is the edge where bit_cnt==7. In SEARCH, bit_cnt is forced so that the COMMA-detect edge acts as a boundary.
- SEARCH:
  - Bit-by-bit sliding compare.
  - If sr_next==COMMA: bit_cnt<=0, comma_cnt<=1, go to ALIGN.
  - Otherwise stay in SEARCH.
- ALIGN:
  - Compare only at boundaries. Non-boundary edges: bit_cnt++ only.
  - Boundary with sr_next==COMMA: comma_cnt++. If comma_cnt+1==LOCK_COUNT, go to LOCKED and set active<=1 on that same edge.
  - Boundary with sr_next!=COMMA: go to SEARCH, comma_cnt<=0. No re-scan of the failing byte.
- LOCKED, at each boundary:
  - byte_strobe<=1.
  - sr_next==COMMA: valid_out<=0, data_out unchanged.
  - Otherwise: data_out<=sr_next, valid_out<=1.
  - Non-boundary edges: byte_strobe<=0; data_out/valid_out hold.
- Latency: data_out/valid_out/byte_strobe update on the same edge that samples the byte's 8th bit. Values are visible after that edge and held for 8 cycles.
- Lock is lost only by reset. In LOCKED, COMMA is idle, never an error. Any byte value other than COMMA is data.
- In SEARCH/ALIGN: valid_out=0, byte_strobe=0, data_out retains its last value (0 after reset).
- Lock timing: with commas from bit 0 after reset, active rises on the edge sampling bit 8*LOCK_COUNT (edge 32 for LOCK_COUNT=4).
- Arbitrary bit phase: leading junk bits before the first COMMA only delay lock; alignment is taken from the COMMA.
- Reset asserted mid-LOCKED: all outputs clear asynchronously. After release, full reacquisition is required (LOCK_COUNT commas).

Test Plan:
- Reset: assert reset with serial_in toggling -> data_out=0, valid_out=0, active=0, byte_strobe=0 immediately, before any clk_8f edge.
- Basic lock: 4x 0xBC MSB-first from first edge after reset -> active=1 after edge 32, not earlier; then 0xA5 -> on edge 40 data_out=0xA5, valid_out=1, byte_strobe high exactly 1 cycle.
- Bit offset: 3 junk bits (101) then 5x 0xBC, 0x3C -> locks at edge 35; data_out=0x3C, valid_out=1 at edge 51. No false lock on the junk bits.
- Broken preamble: 0xBC,0xBC,0xBC,0x00, then 4x 0xBC -> active stays 0 through the 0x00, returns to SEARCH, and locks only after the later 4 commas.
- Idle in stream: locked; send 0x11, 0xBC, 0x22 -> valid_out 1 (0x11), then 0 with data_out still 0x11, then 1 (0x22). byte_strobe pulses on all three boundaries.
- Mid-lock reset: locked and streaming; assert reset mid-byte for 2 cycles -> outputs clear immediately. After release, 0x55 without commas is not output (active=0) until 4 commas are received.
